// File: rtl/intersection_phase_scheduler_if.sv
// Request/timing inputs and signal-head outputs of the phase scheduler.
interface intersection_phase_scheduler_if;
   logic       tick_en;
   logic       ns_req;
   logic       ew_req;
   logic       ped_req;
   logic       ns_red;
   logic       ns_yellow;
   logic       ns_green;
   logic       ew_red;
   logic       ew_yellow;
   logic       ew_green;
   logic       walk;
   logic [2:0] phase;
   logic       ped_pending;

   modport master (
      output tick_en, ns_req, ew_req, ped_req,
      input  ns_red, ns_yellow, ns_green,
      input  ew_red, ew_yellow, ew_green,
      input  walk, phase, ped_pending
   );

   modport slave (
      input  tick_en, ns_req, ew_req, ped_req,
      output ns_red, ns_yellow, ns_green,
      output ew_red, ew_yellow, ew_green,
      output walk, phase, ped_pending
   );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Two-head intersection sequencer with all-red clearance and a latched
// pedestrian walk phase; all outputs are registered decodes of the state.
module intersection_phase_scheduler #(
   parameter int GREEN_TICKS  = 8,
   parameter int YELLOW_TICKS = 3,
   parameter int ALLRED_TICKS = 2,
   parameter int WALK_TICKS   = 6,
   parameter int CNT_W        = 8
) (
   input logic                          clk,
   input logic                          rst_n,
   intersection_phase_scheduler_if.slave bus
);

   typedef enum logic [2:0] {
      ALLRED    = 3'd0,
      NS_GREEN  = 3'd1,
      NS_YELLOW = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      PED_WALK  = 3'd5
   } state_e;

   localparam logic [CNT_W-1:0] G_LD = CNT_W'(GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0] Y_LD = CNT_W'(YELLOW_TICKS - 1);
   localparam logic [CNT_W-1:0] A_LD = CNT_W'(ALLRED_TICKS - 1);
   localparam logic [CNT_W-1:0] W_LD = CNT_W'(WALK_TICKS - 1);

   // lamp vector: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
   localparam logic [6:0] LAMP_RST = 7'b1001000;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             dir_q, dir_d;
   logic             ped_q, ped_d;
   logic [6:0]       lamp_q;
   logic             expire;

   function automatic logic [CNT_W-1:0] load(state_e s);
      case (s)
         NS_GREEN, EW_GREEN:   return G_LD;
         NS_YELLOW, EW_YELLOW: return Y_LD;
         PED_WALK:             return W_LD;
         default:              return A_LD;
      endcase
   endfunction

   function automatic logic [6:0] lamps(state_e s);
      case (s)
         NS_GREEN:  return 7'b0011000;
         NS_YELLOW: return 7'b0101000;
         EW_GREEN:  return 7'b1000010;
         EW_YELLOW: return 7'b1000100;
         PED_WALK:  return 7'b1001001;
         default:   return LAMP_RST;
      endcase
   endfunction

   assign expire = bus.tick_en && (timer_q == '0);

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      ped_d   = ped_q;
      timer_d = timer_q;
      case (state_q)
         ALLRED: begin
            if (expire) begin
               if (ped_q)      state_d = PED_WALK;
               else if (dir_q) state_d = EW_GREEN;
               else            state_d = NS_GREEN;
            end
         end
         NS_GREEN: begin
            if (expire && (bus.ew_req || ped_q))
               state_d = NS_YELLOW;
         end
         NS_YELLOW: begin
            if (expire) begin
               state_d = ALLRED;
               dir_d   = 1'b1;
            end
         end
         EW_GREEN: begin
            if (expire && (bus.ns_req || ped_q))
               state_d = EW_YELLOW;
         end
         EW_YELLOW: begin
            if (expire) begin
               state_d = ALLRED;
               dir_d   = 1'b0;
            end
         end
         PED_WALK: begin
            if (expire) state_d = ALLRED;
         end
         default: state_d = ALLRED;
      endcase

      // entering the walk phase consumes the request, even one arriving now
      if (state_d == PED_WALK && state_q != PED_WALK)
         ped_d = 1'b0;
      else if (state_q != PED_WALK && bus.ped_req)
         ped_d = 1'b1;

      if (state_d != state_q)
         timer_d = load(state_d);
      else if (bus.tick_en && timer_q != '0)
         timer_d = timer_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ALLRED;
         timer_q <= A_LD;
         dir_q   <= 1'b0;
         ped_q   <= 1'b0;
         lamp_q  <= LAMP_RST;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         dir_q   <= dir_d;
         ped_q   <= ped_d;
         lamp_q  <= lamps(state_d);
      end
   end

   assign bus.ns_red      = lamp_q[6];
   assign bus.ns_yellow   = lamp_q[5];
   assign bus.ns_green    = lamp_q[4];
   assign bus.ew_red      = lamp_q[3];
   assign bus.ew_yellow   = lamp_q[2];
   assign bus.ew_green    = lamp_q[1];
   assign bus.walk        = lamp_q[0];
   assign bus.phase       = state_q;
   assign bus.ped_pending = ped_q;

endmodule
